// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the IF and DM requesters
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          stall_if,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int WW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, nxt;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] starve_cnt;
    logic owner, we_q, grant_dm, last_wait;
    // IF only overrides DM once it has watched STARVE_MAX DM grants go by
    assign grant_dm  = dm_req && !(if_req && starve_cnt == SW'(STARVE_MAX));
    assign last_wait = state == WAIT && wait_cnt == WW'(MEM_LAT - 1);
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE  ? ((if_req || dm_req) ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (last_wait ? DONE : WAIT) : IDLE;
    end
    always_comb begin
        mem_en    = state == ISSUE;
        mem_we    = mem_en && we_q;
        if_valid  = state == DONE && !owner;
        dm_valid  = state == DONE && owner;
        stall_if  = if_req && !if_valid;
        stall_mem = dm_req && !dm_valid;
    end
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            owner      <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (state == IDLE) begin
                starve_cnt <= (if_req && grant_dm) ? starve_cnt + 1'b1 : '0;
                if (if_req || dm_req) begin
                    owner     <= grant_dm;
                    we_q      <= grant_dm && dm_we;
                    mem_addr  <= grant_dm ? dm_addr : if_addr;
                    mem_wdata <= grant_dm ? dm_wdata : '0;
                end
            end
            if (state == ISSUE) wait_cnt <= '0;
            if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (last_wait && !we_q && owner) dm_rdata <= mem_rdata;
            if (last_wait && !we_q && !owner) if_rdata <= mem_rdata;
        end
    end
endmodule
